// File: rtl/labfinal_soc_pio_pkg.sv
// Shared constants for the lab-final SoC PIO blocks: register word addresses
// and edge-capture selection.
package labfinal_soc_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  function automatic logic edge_hit(input int edge_type, input logic rise, input logic fall);
    case (edge_type)
      EDGE_RISE: return rise;
      EDGE_FALL: return fall;
      default:   return rise | fall;
    endcase
  endfunction

endpackage

// File: rtl/labfinal_soc_key_debounce.sv
// One input bit: two-flop synchroniser, stability counter, debounced level
// and single-clock rise/fall pulses.
module labfinal_soc_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic        meta_q;
  logic        sync_q;
  logic        stable_q, stable_d;
  logic        stable_dly_q;
  logic [15:0] cnt_q, cnt_d;

  // Any sample that agrees with the accepted level restarts the count.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q       <= 1'b0;
      sync_q       <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      meta_q       <= in_bit;
      sync_q       <= meta_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign rise   = stable_q & ~stable_dly_q;
  assign fall   = ~stable_q & stable_dly_q;

endmodule

// File: rtl/labfinal_soc_key_in.sv
// Avalon-MM key/switch input port: debounced DATA, IRQMASK, and a
// write-1-to-clear EDGECAP register driving a level interrupt.
module labfinal_soc_key_in #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  import labfinal_soc_pio_pkg::*;

  logic [WIDTH-1:0] stable, rise, fall, edge_vec;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] clr;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    labfinal_soc_key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .in_bit (in_port[i]),
      .stable (stable[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
    assign edge_vec[i] = edge_hit(EDGE_TYPE, rise[i], fall[i]);
  end

  // Set is OR-ed in after the clear so a same-clock edge is never lost.
  always_comb begin
    wr_en     = chipselect & ~write_n;
    irqmask_d = irqmask_q;
    clr       = '0;
    if (wr_en && address == ADDR_IRQMASK) irqmask_d = writedata[WIDTH-1:0];
    if (wr_en && address == ADDR_EDGECAP) clr = writedata[WIDTH-1:0];
    edgecap_d = (edgecap_q & ~clr) | edge_vec;

    readdata_d = '0;
    case (address)
      ADDR_DATA:    readdata_d[WIDTH-1:0] = stable;
      ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
      ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata     = readdata_q;
  assign irq          = |(edgecap_q & irqmask_q);
  assign unused_wdata = ^writedata;

endmodule

// File: tb/tb_labfinal_soc_key_in.sv
// Bench for labfinal_soc_key_in: falling-edge instance plus an any-edge
// instance, register vectors from a table and hand sequences for timing.
module tb_labfinal_soc_key_in;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port, in_port2;
  logic [31:0] readdata, readdata2;
  logic        irq, irq2;

  always #5 clk = ~clk;

  labfinal_soc_key_in #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  labfinal_soc_key_in #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port2),
    .readdata(readdata2), .irq(irq2)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    bit          is_wr;
    bit          cs;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_irq;
    string       name;
  } vec_t;
  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected value is queued when the address is driven and retired when
  // the registered readdata appears one clock later.
  task automatic rd(input bit sel, input logic [1:0] a, input logic [31:0] exp, input string name);
    exp_t e;
    address = a;
    e.exp   = exp;
    e.name  = name;
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    check(e.name, sel ? readdata2 : readdata, e.exp);
  endtask

  task automatic wr(input bit cs, input logic [1:0] a, input logic [31:0] d);
    chipselect = cs;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{1, 1, 2'd3, 32'h9,        32'h0, 1'b1, "clr edgecap 9"};
    vecs[1]  = '{0, 0, 2'd3, 32'h0,        32'h2, 1'b1, "edgecap after sel clr"};
    vecs[2]  = '{0, 0, 2'd1, 32'h0,        32'h0, 1'b1, "addr1 reads 0"};
    vecs[3]  = '{1, 1, 2'd1, 32'hFFFFFFFF, 32'h0, 1'b1, "write addr1"};
    vecs[4]  = '{0, 0, 2'd1, 32'h0,        32'h0, 1'b1, "addr1 still 0"};
    vecs[5]  = '{1, 1, 2'd0, 32'hF,        32'h0, 1'b1, "write data"};
    vecs[6]  = '{0, 0, 2'd0, 32'h0,        32'h4, 1'b1, "data unchanged"};
    vecs[7]  = '{1, 1, 2'd2, 32'hF,        32'h0, 1'b1, "mask F"};
    vecs[8]  = '{0, 0, 2'd2, 32'h0,        32'hF, 1'b1, "mask readback F"};
    vecs[9]  = '{1, 1, 2'd2, 32'hFFFFFFF0, 32'h0, 1'b0, "mask 0 upper ignored"};
    vecs[10] = '{0, 0, 2'd2, 32'h0,        32'h0, 1'b0, "mask readback 0"};
    vecs[11] = '{1, 0, 2'd2, 32'hF,        32'h0, 1'b0, "write without cs"};
    vecs[12] = '{0, 0, 2'd2, 32'h0,        32'h0, 1'b0, "mask after no-cs"};
    vecs[13] = '{1, 1, 2'd3, 32'hF,        32'h0, 1'b0, "clr all edgecap"};

    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;
    in_port    = 4'hF;
    in_port2   = 4'hF;
    cyc(3);
    reset_n = 1'b1;

    // Reset values, then DATA settles exactly on the sixth clock
    check("irq after reset", {31'b0, irq}, 32'h0);
    rd(0, 2'd0, 32'h0, "data after reset");
    rd(0, 2'd2, 32'h0, "irqmask after reset");
    rd(0, 2'd3, 32'h0, "edgecap after reset");
    rd(0, 2'd0, 32'h0, "data clk4");
    rd(0, 2'd0, 32'h0, "data clk5");
    rd(0, 2'd0, 32'h0, "data clk6 pre");
    rd(0, 2'd0, 32'hF, "data settled F");
    rd(0, 2'd3, 32'h0, "no capture on rise");
    check("irq idle", {31'b0, irq}, 32'h0);

    // Three-clock glitch is filtered
    in_port = 4'hD;
    cyc(3);
    in_port = 4'hF;
    cyc(6);
    rd(0, 2'd0, 32'hF, "glitch data");
    rd(0, 2'd3, 32'h0, "glitch edgecap");

    // Four-clock drop is accepted
    in_port = 4'hD;
    for (int k = 0; k < 7; k++)
      rd(0, 2'd0, (k < 6) ? 32'hF : 32'hD, $sformatf("drop data k%0d", k));
    rd(0, 2'd3, 32'h2, "drop edgecap");
    check("irq masked", {31'b0, irq}, 32'h0);

    // Masking
    wr(1, 2'd2, 32'h2);
    check("irq unmasked", {31'b0, irq}, 32'h1);
    rd(0, 2'd2, 32'h2, "irqmask readback");
    wr(1, 2'd3, 32'h2);
    check("irq after clear", {31'b0, irq}, 32'h0);
    rd(0, 2'd3, 32'h0, "edgecap cleared");

    // Set and clear on the same clock: set wins
    in_port = 4'hC;
    cyc(6);
    wr(1, 2'd3, 32'h1);
    rd(0, 2'd3, 32'h1, "collision set wins");
    wr(1, 2'd3, 32'h1);
    rd(0, 2'd3, 32'h0, "collision later clear");

    // Simultaneous falls on bits 0,1,3
    in_port = 4'hF;
    cyc(8);
    rd(0, 2'd3, 32'h0, "rise not captured");
    in_port = 4'h4;
    cyc(8);
    rd(0, 2'd3, 32'hB, "simultaneous capture");
    check("irq bit1", {31'b0, irq}, 32'h1);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_wr) wr(vecs[i].cs, vecs[i].addr, vecs[i].wdata);
      else               rd(0, vecs[i].addr, vecs[i].exp_rd, vecs[i].name);
      check({"irq ", vecs[i].name}, {31'b0, irq}, {31'b0, vecs[i].exp_irq});
    end

    // Any-edge instance: fall then rise on bit 3
    in_port2 = 4'h7;
    cyc(7);
    rd(1, 2'd3, 32'h8, "any fall capture");
    in_port2 = 4'hF;
    wr(1, 2'd3, 32'h8);
    rd(1, 2'd3, 32'h0, "any cleared");
    cyc(4);
    rd(1, 2'd3, 32'h0, "any rise pending");
    rd(1, 2'd3, 32'h8, "any rise capture");
    rd(1, 2'd0, 32'hF, "any data");
    wr(1, 2'd2, 32'h8);
    check("irq any", {31'b0, irq2}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
